// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the parametrised non-restoring divider.
//   div_state_t   : controller states (IDLE, RUN, FINISH)
//   div_cnt_width : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // The step counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int div_cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_nr_param_if.sv
// -----------------------------------------------------------------------------
// div_nr_param_if
// Request/result bundle between the execute-stage control and the divider.
//   start, is_signed, dividend, divisor : request (sampled when accepted)
//   q, r, div_zero                      : registered, held results
//   busy                                : operation in progress
//   done                                : one-cycle result-valid pulse
// Modports: master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_nr_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/div_nr_step.sv
// -----------------------------------------------------------------------------
// div_nr_step
// One combinational non-restoring division step on a WIDTH+1-bit partial
// remainder. The remainder's sign bit is carried separately as r_sign, so
// only the low WIDTH bits travel on rem_i/rem_o.
//   rem_i     : partial remainder, low WIDTH bits
//   bit_i     : next dividend bit (quotient register MSB)
//   dvs_i     : divisor magnitude
//   r_sign_i  : sign of the current partial remainder (1 = negative)
//   rem_o     : next partial remainder, low WIDTH bits
//   r_sign_o  : sign of the next partial remainder
//   q_bit_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             r_sign_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             r_sign_o,
    output logic             q_bit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;
    logic [WIDTH:0] sum;

    // The shift drops the old sign bit: the post-add/sub remainder always lies
    // in [-D, D), so modulo-2^(WIDTH+1) arithmetic still yields the exact value.
    assign shifted = {rem_i, bit_i};
    assign dvs_ext = {1'b0, dvs_i};
    assign sum     = r_sign_i ? (shifted + dvs_ext) : (shifted - dvs_ext);

    assign rem_o    = sum[WIDTH-1:0];
    assign r_sign_o = sum[WIDTH];
    assign q_bit_o  = ~sum[WIDTH];
endmodule

// File: rtl/div_nr_param.sv
// -----------------------------------------------------------------------------
// div_nr_param
// Multi-cycle parametrised non-restoring divider, signed or unsigned per
// operation. Operands are captured on accept, WIDTH steps run one per cycle,
// then a FINISH cycle corrects the remainder, fixes signs and writes the
// held results with a one-cycle done pulse. Divide by zero skips RUN.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : div_nr_param_if.slave (start/is_signed/dividend/divisor in;
//           q/r/busy/done/div_zero out, all registered)
// -----------------------------------------------------------------------------
module div_nr_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    div_nr_param_if.slave   bus
);
    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             r_sign_q, r_sign_d;
    logic             sn_q, sn_d;
    logic             sd_q, sd_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic             in_sn, in_sd;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_sign;
    logic             step_qbit;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes at accept; the most-negative value maps onto itself, which
    // is the correct unsigned magnitude.
    assign in_sn   = bus.is_signed & bus.dividend[WIDTH-1];
    assign in_sd   = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvd_mag = in_sn ? (-bus.dividend) : bus.dividend;
    assign dvs_mag = in_sd ? (-bus.divisor)  : bus.divisor;

    div_nr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (quo_q[WIDTH-1]),
        .dvs_i    (dvs_q),
        .r_sign_i (r_sign_q),
        .rem_o    (step_rem),
        .r_sign_o (step_sign),
        .q_bit_o  (step_qbit)
    );

    // Final correction: a negative partial remainder gets the divisor added
    // back once. The result lies in [0, D), so WIDTH bits are exact.
    assign rem_fix = r_sign_q ? (rem_q + dvs_q) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        r_sign_d = r_sign_q;
        sn_d     = sn_q;
        sd_d     = sd_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        q_d      = q_q;
        r_d      = r_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sn_d     = in_sn;
                    sd_d     = in_sd;
                    quo_d    = dvd_mag;
                    dvs_d    = dvs_mag;
                    rem_d    = '0;
                    r_sign_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    zero_d   = (bus.divisor == '0);
                    state_d  = (bus.divisor == '0) ? FINISH : RUN;
                end
            end

            RUN: begin
                rem_d    = step_rem;
                r_sign_d = step_sign;
                quo_d    = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = zero_q;
                state_d = IDLE;
                if (zero_q) begin
                    // quo_q still holds |dividend|; undoing the sign fix
                    // restores the original bit pattern.
                    q_d = '1;
                    r_d = sn_q ? (-quo_q) : quo_q;
                end else begin
                    q_d = (sn_q ^ sd_q) ? (-quo_q) : quo_q;
                    r_d = sn_q ? (-rem_fix) : rem_fix;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            r_sign_q <= 1'b0;
            sn_q     <= 1'b0;
            sd_q     <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            r_sign_q <= r_sign_d;
            sn_q     <= sn_d;
            sd_q     <= sd_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            q_q      <= q_d;
            r_q      <= r_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule
